ack_bus_arb_rr: RTL and testbench

//  Registered, parametrised arbiter for the shared ACK bus. Up to NUM_SRC requesters
//  (MEM/SHA/AES/CTRL by default) contend, one winner holds the bus until release.

---
 rtl/ack_bus_arb_rr_if.sv | 38 +++
 rtl/ack_bus_arb_rr.sv | 141 ++++++++++++++
 tb/tb_ack_bus_arb_rr.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ack_bus_arb_rr_if.sv
// ACK bus bundle between the arbiter (master) and the requesting modules (slave).
// ACK_ARB_STATS_EN adds the grant/timeout statistics counters to the bundle.
interface ack_bus_arb_rr_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
);
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] done;
  logic [NUM_SRC-1:0] ack_ready;
  logic [ID_W-1:0]    winner_source_id;
  logic               ack_event;
  logic               bus_busy;
  logic               timeout_err;
`ifdef ACK_ARB_STATS_EN
  logic [15:0]        grant_count;
  logic [7:0]         timeout_count;

  modport master (
    input  req, done,
    output ack_ready, winner_source_id, ack_event, bus_busy, timeout_err,
           grant_count, timeout_count
  );
  modport slave (
    output req, done,
    input  ack_ready, winner_source_id, ack_event, bus_busy, timeout_err,
           grant_count, timeout_count
  );
`else
  modport master (
    input  req, done,
    output ack_ready, winner_source_id, ack_event, bus_busy, timeout_err
  );
  modport slave (
    output req, done,
    input  ack_ready, winner_source_id, ack_event, bus_busy, timeout_err
  );
`endif
endinterface

// File: rtl/ack_bus_arb_rr.sv
// Shared ACK bus arbiter: fixed-priority or round-robin, hold timeout, one-cycle turnaround.
// Optional macro ACK_ARB_STATS_EN adds saturating grant_count / timeout_count outputs.
module ack_bus_arb_rr #(
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned ID_W     = $clog2(NUM_SRC),
  parameter int unsigned RR_MODE  = 0,
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  ack_bus_arb_rr_if.master    bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_SRC - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_ack_ready;
  logic [NUM_SRC-1:0] w_ack_ready_nxt;
  logic [ID_W-1:0]    r_winner;
  logic [ID_W-1:0]    w_winner_nxt;
  logic               r_ack_event;
  logic               w_ack_event_nxt;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [CNT_W-1:0]   w_hold_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    w_rr_nxt;
  logic               w_timeout_err;

  logic [ID_W-1:0]    w_pick;
  logic               w_found;
  logic [31:0]        w_base;
  logic [31:0]        w_idx;
  logic               w_win_done;
  logic               w_win_req;
  logic               w_hold_hit;

  // Scan starts at rr_ptr in round-robin mode, at 0 otherwise; first set request wins.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_base  = (RR_MODE != 0) ? 32'(r_rr_ptr) : 32'd0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_idx = (w_base + k) % NUM_SRC;
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = ID_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ack_ready_nxt = r_ack_ready;
    w_winner_nxt    = r_winner;
    w_ack_event_nxt = 1'b0;
    w_hold_nxt      = r_hold_cnt;
    w_rr_nxt        = r_rr_ptr;
    w_timeout_err   = 1'b0;
    w_win_done      = bus.done[r_winner];
    w_win_req       = bus.req[r_winner];
    w_hold_hit      = (HOLD_MAX != 0) && (r_hold_cnt == HOLD_LAST);

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt             = ST_GRANT;
          w_ack_ready_nxt         = '0;
          w_ack_ready_nxt[w_pick] = 1'b1;
          w_winner_nxt            = w_pick;
          w_ack_event_nxt         = 1'b1;
          w_hold_nxt              = '0;
        end
      end
      ST_GRANT: begin
        if (r_hold_cnt != '1) w_hold_nxt = r_hold_cnt + 1'b1;
        // A real release (done or withdraw) in the timeout cycle suppresses the error pulse.
        if (w_win_done || !w_win_req || w_hold_hit) begin
          w_state_nxt     = ST_RELEASE;
          w_ack_ready_nxt = '0;
          w_timeout_err   = w_hold_hit && !w_win_done && w_win_req;
          if (RR_MODE != 0) w_rr_nxt = (r_winner == LAST_ID) ? '0 : r_winner + 1'b1;
        end
      end
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ack_ready <= '0;
      r_winner    <= '0;
      r_ack_event <= 1'b0;
      r_hold_cnt  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack_ready <= w_ack_ready_nxt;
      r_winner    <= w_winner_nxt;
      r_ack_event <= w_ack_event_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_rr_ptr    <= w_rr_nxt;
    end
  end

  assign bus.ack_ready        = r_ack_ready;
  assign bus.winner_source_id = r_winner;
  assign bus.ack_event        = r_ack_event;
  assign bus.bus_busy         = (r_state != ST_IDLE);
  assign bus.timeout_err      = w_timeout_err;

`ifdef ACK_ARB_STATS_EN
  logic [15:0] r_grant_count;
  logic [7:0]  r_timeout_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_count   <= '0;
      r_timeout_count <= '0;
    end else begin
      if (r_ack_event && (r_grant_count != '1))     r_grant_count   <= r_grant_count + 1'b1;
      if (w_timeout_err && (r_timeout_count != '1)) r_timeout_count <= r_timeout_count + 1'b1;
    end
  end

  assign bus.grant_count   = r_grant_count;
  assign bus.timeout_count = r_timeout_count;
`endif

endmodule

// File: tb/tb_ack_bus_arb_rr.sv
// Directed bench: fixed-priority, round-robin and HOLD_MAX=4 arbiter instances side by side.
module tb_ack_bus_arb_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ack_bus_arb_rr_if #(.NUM_SRC(4)) ifa ();
  ack_bus_arb_rr_if #(.NUM_SRC(4)) ifb ();
  ack_bus_arb_rr_if #(.NUM_SRC(4)) ifc ();

  ack_bus_arb_rr #(.NUM_SRC(4), .RR_MODE(0), .HOLD_MAX(15)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.master));
  ack_bus_arb_rr #(.NUM_SRC(4), .RR_MODE(1), .HOLD_MAX(15)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.master));
  ack_bus_arb_rr #(.NUM_SRC(4), .RR_MODE(0), .HOLD_MAX(4)) dut_c (
    .clk (clk), .rst (rst), .bus (ifc.master));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    ifa.req = '0; ifa.done = '0;
    ifb.req = '0; ifb.done = '0;
    ifc.req = '0; ifc.done = '0;

    step(2);
    rst = 1'b0;
    chk("rst_ack_ready", 32'(ifa.ack_ready), 0);
    chk("rst_winner",    32'(ifa.winner_source_id), 0);
    chk("rst_ack_event", 32'(ifa.ack_event), 0);
    chk("rst_busy",      32'(ifa.bus_busy), 0);
    chk("rst_timeout",   32'(ifa.timeout_err), 0);

    // Fixed priority: lowest of 1110 is source 1
    ifa.req = 4'b1110;
    step(1);
    chk("fp_grant1",  32'(ifa.ack_ready), 32'h2);
    chk("fp_win1",    32'(ifa.winner_source_id), 1);
    chk("fp_event1",  32'(ifa.ack_event), 1);
    chk("fp_busy1",   32'(ifa.bus_busy), 1);
    step(1);
    chk("fp_event_drop", 32'(ifa.ack_event), 0);
    chk("fp_hold",       32'(ifa.ack_ready), 32'h2);
    ifa.done = 4'b0010;
    step(1);
    ifa.done = '0;
    ifa.req  = 4'b1100;
    chk("fp_rel_ack",  32'(ifa.ack_ready), 0);
    chk("fp_rel_busy", 32'(ifa.bus_busy), 1);
    chk("fp_rel_win",  32'(ifa.winner_source_id), 1);
    step(1);
    chk("fp_idle_busy", 32'(ifa.bus_busy), 0);
    chk("fp_idle_win",  32'(ifa.winner_source_id), 1);
    step(1);
    chk("fp_grant2",  32'(ifa.ack_ready), 32'h4);
    chk("fp_win2",    32'(ifa.winner_source_id), 2);
    chk("fp_event2",  32'(ifa.ack_event), 1);

    // Non-winner done ignored, then winner withdraws
    ifa.done = 4'b1000;
    step(1);
    ifa.done = '0;
    chk("ign_done_ack",  32'(ifa.ack_ready), 32'h4);
    chk("ign_done_busy", 32'(ifa.bus_busy), 1);
    ifa.req = 4'b1000;
    step(1);
    chk("wd_rel_ack",  32'(ifa.ack_ready), 0);
    chk("wd_rel_busy", 32'(ifa.bus_busy), 1);
    chk("wd_no_tmo",   32'(ifa.timeout_err), 0);
    step(2);
    chk("wd_grant3", 32'(ifa.ack_ready), 32'h8);
    chk("wd_win3",   32'(ifa.winner_source_id), 3);
    ifa.done = 4'b1000;
    step(1);
    ifa.done = '0;
    ifa.req  = '0;
    step(1);
    chk("a_idle", 32'(ifa.bus_busy), 0);

    // Round-robin: 0,1,2,3,0 with 3 cycles between grants
    ifb.req = 4'b1111;
    step(1);
    chk("rr_grant0", 32'(ifb.ack_ready), 32'h1);
    chk("rr_win0",   32'(ifb.winner_source_id), 0);
    for (int i = 1; i <= 4; i++) begin
      ifb.done = ifb.ack_ready;
      step(1);
      ifb.done = '0;
      chk("rr_rel_ack", 32'(ifb.ack_ready), 0);
      step(1);
      chk("rr_idle_busy", 32'(ifb.bus_busy), 0);
      step(1);
      chk("rr_grant", 32'(ifb.ack_ready), 32'(1 << (i % 4)));
      chk("rr_win",   32'(ifb.winner_source_id), 32'(i % 4));
      chk("rr_event", 32'(ifb.ack_event), 1);
    end
    ifb.done = 4'b0001;
    step(1);
    ifb.done = '0;
    ifb.req  = '0;
    step(1);

    // Timeout with HOLD_MAX=4
    ifc.req = 4'b0001;
    step(1);
    chk("to_grant",  32'(ifc.ack_ready), 32'h1);
    chk("to_event",  32'(ifc.ack_event), 1);
    chk("to_terr0",  32'(ifc.timeout_err), 0);
    step(2);
    chk("to_hold3",  32'(ifc.ack_ready), 32'h1);
    chk("to_terr2",  32'(ifc.timeout_err), 0);
    step(1);
    chk("to_hold4",  32'(ifc.ack_ready), 32'h1);
    chk("to_terr4",  32'(ifc.timeout_err), 1);
    step(1);
    chk("to_rel_ack",  32'(ifc.ack_ready), 0);
    chk("to_rel_terr", 32'(ifc.timeout_err), 0);
    chk("to_rel_busy", 32'(ifc.bus_busy), 1);
    step(1);
    chk("to_idle_ack", 32'(ifc.ack_ready), 0);
    step(1);
    chk("to_regrant",  32'(ifc.ack_ready), 32'h1);
    chk("to_reevent",  32'(ifc.ack_event), 1);
    step(3);
    ifc.done = 4'b0001;
    #1;
    chk("to_done_wins_ack",  32'(ifc.ack_ready), 32'h1);
    chk("to_done_wins_terr", 32'(ifc.timeout_err), 0);
    step(1);
    ifc.done = '0;
    ifc.req  = '0;
    chk("to_done_rel", 32'(ifc.ack_ready), 0);
    step(1);

`ifdef ACK_ARB_STATS_EN
    chk("st_a_grants", 32'(ifa.grant_count), 3);
    chk("st_b_grants", 32'(ifb.grant_count), 5);
    chk("st_c_grants", 32'(ifc.grant_count), 2);
    chk("st_c_tmo",    32'(ifc.timeout_count), 1);
    chk("st_b_tmo",    32'(ifb.timeout_count), 0);
`endif

    // Reset held 2 cycles in the middle of a grant
    ifa.req = 4'b0100;
    step(1);
    chk("mr_grant", 32'(ifa.ack_ready), 32'h4);
    step(1);
    rst = 1'b1;
    step(1);
    chk("mr_ack1",   32'(ifa.ack_ready), 0);
    chk("mr_busy1",  32'(ifa.bus_busy), 0);
    chk("mr_event1", 32'(ifa.ack_event), 0);
    step(1);
    rst = 1'b0;
    chk("mr_ack2",  32'(ifa.ack_ready), 0);
    chk("mr_win2",  32'(ifa.winner_source_id), 0);
`ifdef ACK_ARB_STATS_EN
    chk("mr_stats", 32'(ifb.grant_count), 0);
`endif
    step(1);
    chk("mr_regrant", 32'(ifa.ack_ready), 32'h4);
    chk("mr_reevent", 32'(ifa.ack_event), 1);
    ifa.req = '0;
    step(2);
    chk("mr_final_idle", 32'(ifa.bus_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
